// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Host loader handshake between the host/debug side and the run controller.
//   ld_valid  host -> ctrl  an instruction word is offered
//   ld_ready  ctrl -> host  controller accepts the word this cycle
//   ld_addr   host -> ctrl  instruction-memory word address
//   ld_data   host -> ctrl  32-bit instruction word
//   ld_done   host -> ctrl  host has finished loading
// master = host side, slave = run controller side.
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int IMEM_AW = 6
);
    logic               ld_valid;
    logic               ld_ready;
    logic [IMEM_AW-1:0] ld_addr;
    logic [31:0]        ld_data;
    logic               ld_done;

    modport master (
        output ld_valid,
        output ld_addr,
        output ld_data,
        output ld_done,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        input  ld_done,
        output ld_ready
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the single-cycle core. Holds the core in reset while the
// host loads instruction memory, then runs, single-steps or halts it through
// a clock enable. Halts on host request, PC breakpoint or cycle budget and
// reports the cause.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   ld              host loader handshake (slave side)
//   start/step      run/resume pulse, single-step pulse
//   halt_req        halt request (in HALT: abort to IDLE)
//   cycle_limit     run budget in executed cycles, 0 = unlimited
//   bp_en, bp_pc    PC breakpoint
//   PC              current core PC
//   cpu_rst         registered active-high core reset
//   cpu_en          combinational core clock enable
//   imem_*          instruction-memory write port
//   state           registered FSM state (IDLE=0 .. HALT=5)
//   cycle_count     registered executed-cycle count, saturating
//   halt_cause      registered halt cause (0 none,1 req,2 bp,3 limit)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int IMEM_AW = 6,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    cpu_run_ctrl_if.slave      ld,
    input  logic               start,
    input  logic               step,
    input  logic               halt_req,
    input  logic [CNT_W-1:0]   cycle_limit,
    input  logic               bp_en,
    input  logic [31:0]        bp_pc,
    input  logic [31:0]        PC,
    output logic               cpu_rst,
    output logic               cpu_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [1:0]         halt_cause
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    state_t             state_r;
    logic               cpu_rst_r;
    logic [CNT_W-1:0]   cycle_count_r;
    logic [1:0]         halt_cause_r;
    logic               skip_bp_r;

    logic               hc_s;
    logic [1:0]         hc_cause_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               cpu_en_s;
    logic               ld_ready_s;

    // Saturating increment of the executed-cycle counter.
    assign count_inc_s = (cycle_count_r == {CNT_W{1'b1}}) ? cycle_count_r
                                                          : cycle_count_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Halt condition while running, in priority order request > breakpoint > budget.
    always_comb begin
        hc_s       = 1'b0;
        hc_cause_s = 2'd0;
        if (halt_req) begin
            hc_s       = 1'b1;
            hc_cause_s = 2'd1;
        end else if (bp_en && (PC == bp_pc) && !skip_bp_r) begin
            hc_s       = 1'b1;
            hc_cause_s = 2'd2;
        end else if ((cycle_limit != {CNT_W{1'b0}}) && (cycle_count_r >= cycle_limit)) begin
            hc_s       = 1'b1;
            hc_cause_s = 2'd3;
        end else begin
            hc_s       = 1'b0;
            hc_cause_s = 2'd0;
        end
    end

    // Core enable and load acceptance; both forced low while reset is held.
    always_comb begin
        cpu_en_s   = 1'b0;
        ld_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: ld_ready_s = 1'b1;
            ST_LOAD: ld_ready_s = 1'b1;
            ST_RUN:  cpu_en_s   = ~hc_s;
            ST_STEP: cpu_en_s   = 1'b1;
            default: begin
                cpu_en_s   = 1'b0;
                ld_ready_s = 1'b0;
            end
        endcase
        if (!RST) begin
            cpu_en_s   = 1'b0;
            ld_ready_s = 1'b0;
        end else begin
            cpu_en_s   = cpu_en_s;
            ld_ready_s = ld_ready_s;
        end
    end

    assign cpu_en      = cpu_en_s;
    assign ld.ld_ready = ld_ready_s;
    assign imem_we     = ld.ld_valid & ld_ready_s;
    assign imem_waddr  = ld.ld_addr;
    assign imem_wdata  = ld.ld_data;

    // Run-control FSM; cpu_rst is registered from the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            cpu_rst_r     <= 1'b1;
            cycle_count_r <= {CNT_W{1'b0}};
            halt_cause_r  <= 2'd0;
            skip_bp_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_rst_r <= 1'b1;
                    if (ld.ld_valid) begin
                        state_r <= ST_LOAD;
                    end else if (start) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    cpu_rst_r <= 1'b1;
                    if (ld.ld_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_CLEAR: begin
                    cycle_count_r <= {CNT_W{1'b0}};
                    halt_cause_r  <= 2'd0;
                    cpu_rst_r     <= 1'b0;
                    state_r       <= ST_RUN;
                end
                ST_RUN: begin
                    cpu_rst_r <= 1'b0;
                    if (hc_s) begin
                        // Halting instruction is not executed, so no count.
                        halt_cause_r <= hc_cause_s;
                        state_r      <= ST_HALT;
                    end else begin
                        cycle_count_r <= count_inc_s;
                        skip_bp_r     <= 1'b0;
                        state_r       <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    cpu_rst_r     <= 1'b0;
                    cycle_count_r <= count_inc_s;
                    state_r       <= ST_HALT;
                end
                ST_HALT: begin
                    if (halt_req) begin
                        cpu_rst_r <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (start) begin
                        // Let the instruction at a breakpoint PC run once on resume.
                        cpu_rst_r <= 1'b0;
                        skip_bp_r <= 1'b1;
                        state_r   <= ST_RUN;
                    end else if (step) begin
                        cpu_rst_r <= 1'b0;
                        state_r   <= ST_STEP;
                    end else begin
                        cpu_rst_r <= 1'b0;
                        state_r   <= ST_HALT;
                    end
                end
                default: begin
                    cpu_rst_r <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rst     = cpu_rst_r;
    assign state       = state_r;
    assign cycle_count = cycle_count_r;
    assign halt_cause  = halt_cause_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl. A tiny core stand-in advances PC by 4 per
// enabled cycle, looping over 0x00..0x1C. Loaded words are queued as expected
// writes and popped when the controller strobes imem_we.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    localparam int IMEM_AW = 6;
    localparam int CNT_W   = 16;

    logic               CLK;
    logic               RST;
    logic               start;
    logic               step;
    logic               halt_req;
    logic [CNT_W-1:0]   cycle_limit;
    logic               bp_en;
    logic [31:0]        bp_pc;
    logic [31:0]        PC;
    logic               cpu_rst;
    logic               cpu_en;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic [2:0]         state;
    logic [CNT_W-1:0]   cycle_count;
    logic [1:0]         halt_cause;

    cpu_run_ctrl_if #(.IMEM_AW(IMEM_AW)) ld_if ();

    cpu_run_ctrl #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ld          (ld_if),
        .start       (start),
        .step        (step),
        .halt_req    (halt_req),
        .cycle_limit (cycle_limit),
        .bp_en       (bp_en),
        .bp_pc       (bp_pc),
        .PC          (PC),
        .cpu_rst     (cpu_rst),
        .cpu_en      (cpu_en),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .state       (state),
        .cycle_count (cycle_count),
        .halt_cause  (halt_cause)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    int base;
    logic [IMEM_AW+31:0] exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core stand-in: PC walks a 8-instruction loop when enabled.
    always @(posedge CLK) begin
        if (cpu_rst === 1'b1) PC <= 32'h0;
        else if (cpu_en === 1'b1) PC <= (PC == 32'h1C) ? 32'h0 : PC + 32'd4;
        else PC <= PC;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample cpu_en after inputs settle, then advance to just past the next edge.
    task automatic cyc();
        #1;
        if (cpu_en === 1'b1) en_cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic load_cycle(input logic v, input logic [IMEM_AW-1:0] a,
                              input logic [31:0] d, input logic done, input logic st);
        ld_if.ld_valid = v;
        ld_if.ld_addr  = a;
        ld_if.ld_data  = d;
        ld_if.ld_done  = done;
        start          = st;
        if (v) exp_q.push_back({a, d});
        #1;
        if (imem_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) chk("ld_spurious_we", 64'd1, 64'd0);
            else chk("ld_word", {imem_waddr, imem_wdata}, exp_q.pop_front());
        end
        @(posedge CLK);
        #1;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_done  = 1'b0;
        start          = 1'b0;
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        cycle_limit = 16'd0; bp_en = 1'b0; bp_pc = 32'h0;
        ld_if.ld_valid = 1'b1; ld_if.ld_addr = 6'd0; ld_if.ld_data = 32'h0; ld_if.ld_done = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;

        // Reset state, with a word offered that must not be written
        chk("rst_state", state, 3'd0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_count", cycle_count, 16'd0);
        chk("rst_cause", halt_cause, 2'd0);
        chk("rst_cpu_en", cpu_en, 1'b0);
        chk("rst_ld_ready", ld_if.ld_ready, 1'b0);
        chk("rst_imem_we", imem_we, 1'b0);
        RST = 1'b1; ld_if.ld_valid = 1'b0;
        #1 chk("idle_ld_ready", ld_if.ld_ready, 1'b1);
        @(posedge CLK); #1;

        // Load four words, start ignored in LOAD, last word together with ld_done
        load_cycle(1'b1, 6'd0, 32'hDEAD0000, 1'b0, 1'b0);
        chk("load_state", state, 3'd1);
        load_cycle(1'b0, 6'd9, 32'h0, 1'b0, 1'b1);
        chk("load_start_ignored", state, 3'd1);
        load_cycle(1'b1, 6'd1, 32'h12345678, 1'b0, 1'b0);
        load_cycle(1'b0, 6'd9, 32'h0, 1'b0, 1'b0);
        load_cycle(1'b1, 6'd2, 32'hA5A5A5A5, 1'b0, 1'b0);
        load_cycle(1'b0, 6'd9, 32'h0, 1'b0, 1'b0);
        load_cycle(1'b1, 6'd3, 32'h0BADF00D, 1'b1, 1'b0);
        chk("load_we_count", we_cnt, 4);
        chk("load_queue_empty", exp_q.size(), 0);
        chk("load_done_state", state, 3'd0);
        chk("load_cpu_rst", cpu_rst, 1'b1);

        // Cycle limit of 17
        cycle_limit = 16'd17;
        base = en_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        chk("clear_state", state, 3'd2);
        chk("clear_cpu_rst", cpu_rst, 1'b1);
        cyc();
        chk("run_cpu_rst", cpu_rst, 1'b0);
        for (int i = 0; i < 100 && state !== 3'd5; i++) cyc();
        chk("lim_state", state, 3'd5);
        chk("lim_en_cycles", en_cnt - base, 17);
        chk("lim_cause", halt_cause, 2'd3);
        chk("lim_count", cycle_count, 16'd17);
        // Resume with the budget still met re-halts at once
        start = 1'b1; cyc(); start = 1'b0;
        chk("lim_resume_state", state, 3'd3);
        #1 chk("lim_resume_en", cpu_en, 1'b0);
        cyc();
        chk("lim_rehalt_state", state, 3'd5);
        chk("lim_rehalt_count", cycle_count, 16'd17);

        // Back to IDLE, then breakpoint at 0x10
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        chk("abort_idle", state, 3'd0);
        cycle_limit = 16'd0; bp_en = 1'b1; bp_pc = 32'h10;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("clear_count", cycle_count, 16'd0);
        chk("clear_cause", halt_cause, 2'd0);
        base = en_cnt;
        for (int i = 0; i < 50 && state === 3'd3 && PC !== 32'h10; i++) cyc();
        #1;
        chk("bp_pc", PC, 32'h10);
        chk("bp_cpu_en", cpu_en, 1'b0);
        cyc();
        chk("bp_state", state, 3'd5);
        chk("bp_cause", halt_cause, 2'd2);
        chk("bp_count", cycle_count, 16'd4);
        chk("bp_en_cycles", en_cnt - base, 4);
        // Resume executes the breakpoint instruction, then halts on the next visit
        base = en_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        #1 chk("bp_resume_en", cpu_en, 1'b1);
        cyc();
        chk("bp_resume_state", state, 3'd3);
        chk("bp_resume_pc", PC, 32'h14);
        for (int i = 0; i < 50 && state !== 3'd5; i++) cyc();
        chk("bp2_state", state, 3'd5);
        chk("bp2_pc", PC, 32'h10);
        chk("bp2_cause", halt_cause, 2'd2);
        chk("bp2_en_cycles", en_cnt - base, 8);
        chk("bp2_count", cycle_count, 16'd12);

        // Three single steps from HALT at the breakpoint
        for (int k = 1; k <= 3; k++) begin
            base = en_cnt;
            step = 1'b1; cyc(); step = 1'b0;
            chk("step_state", state, 3'd4);
            cyc();
            chk("step_halt", state, 3'd5);
            chk("step_en_cycles", en_cnt - base, 1);
            chk("step_count", cycle_count, 16'd12 + 16'(k));
        end
        chk("step_cause_kept", halt_cause, 2'd2);
        chk("step_pc", PC, 32'h1C);

        // start and step together resume
        start = 1'b1; step = 1'b1; cyc(); start = 1'b0; step = 1'b0;
        chk("start_beats_step", state, 3'd3);

        // halt_req in RUN, then again in HALT
        halt_req = 1'b1;
        #1 chk("abort_cpu_en", cpu_en, 1'b0);
        cyc(); halt_req = 1'b0;
        chk("abort_halt", state, 3'd5);
        chk("abort_cause", halt_cause, 2'd1);
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        chk("abort2_state", state, 3'd0);
        chk("abort2_cpu_rst", cpu_rst, 1'b1);

        // Asynchronous reset in the middle of a run
        bp_en = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        for (int i = 0; i < 50 && cycle_count !== 16'd5; i++) cyc();
        chk("mid_run_state", state, 3'd3);
        chk("mid_run_count", cycle_count, 16'd5);
        RST = 1'b0;
        #1;
        chk("async_rst_state", state, 3'd0);
        chk("async_rst_cpu_rst", cpu_rst, 1'b1);
        chk("async_rst_cpu_en", cpu_en, 1'b0);
        chk("async_rst_count", cycle_count, 16'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
